// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the cpu32e2 system bus slave port.
// Read returns are steered back to the issuing master via an in-order ID FIFO.
module bus_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_PENDING = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [1:0]                  masterRead,
    input  logic [1:0]                  masterWrite,
    input  logic [2*ADDR_WIDTH-1:0]     masterAddress,
    input  logic [2*DATA_WIDTH-1:0]     masterWriteData,
    input  logic [2*(DATA_WIDTH/8)-1:0] masterByteEnable,
    output logic [1:0]                  masterWaitRequest,
    output logic [1:0]                  masterReadValid,
    output logic [DATA_WIDTH-1:0]       masterReadData,
    output logic                        slaveRead,
    output logic                        slaveWrite,
    output logic [ADDR_WIDTH-1:0]       slaveAddress,
    output logic [DATA_WIDTH-1:0]       slaveWriteData,
    output logic [DATA_WIDTH/8-1:0]     slaveByteEnable,
    input  logic                        slaveWaitRequest,
    input  logic                        slaveReadValid,
    input  logic [DATA_WIDTH-1:0]       slaveReadData,
    output logic                        protocolError
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int PTR_W = $clog2(MAX_PENDING);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN0 = 2'd1,
        S_OWN1 = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_last;
    logic               r_fifo [MAX_PENDING];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic               r_err;

    logic [1:0]         w_req;
    logic               w_granted;
    logic               w_sel;
    logic               w_rd_req;
    logic               w_wr_req;
    logic               w_full;
    logic               w_empty;
    logic               w_read_block;
    logic               w_slv_rd;
    logic               w_slv_wr;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_stall;
    logic               w_err_set;

    assign w_req     = masterRead | masterWrite;
    assign w_granted = (r_state != S_IDLE);
    assign w_sel     = (r_state == S_OWN1);
    assign w_rd_req  = masterRead[w_sel];
    assign w_wr_req  = masterWrite[w_sel];

    assign w_full  = (r_count == CNT_W'(MAX_PENDING));
    assign w_empty = (r_count == '0);

    // A return in the same cycle frees a slot, so a full FIFO can still take a read
    assign w_read_block = w_full & ~slaveReadValid;

    assign w_slv_wr = w_granted & w_wr_req;
    assign w_slv_rd = w_granted & w_rd_req & ~w_wr_req & ~w_read_block;
    assign w_accept = (w_slv_rd | w_slv_wr) & ~slaveWaitRequest;
    assign w_push   = w_accept & w_slv_rd;
    assign w_pop    = slaveReadValid & ~w_empty;

    assign w_stall   = slaveWaitRequest | (w_read_block & w_rd_req & ~w_wr_req);
    assign w_err_set = (w_granted & w_rd_req & w_wr_req)
                     | (slaveReadValid & w_empty);

    assign slaveRead  = w_slv_rd;
    assign slaveWrite = w_slv_wr;

    always_comb begin
        slaveAddress    = masterAddress[0 +: ADDR_WIDTH];
        slaveWriteData  = masterWriteData[0 +: DATA_WIDTH];
        slaveByteEnable = masterByteEnable[0 +: BE_W];
        if (w_sel) begin
            slaveAddress    = masterAddress[ADDR_WIDTH +: ADDR_WIDTH];
            slaveWriteData  = masterWriteData[DATA_WIDTH +: DATA_WIDTH];
            slaveByteEnable = masterByteEnable[BE_W +: BE_W];
        end
    end

    always_comb begin
        masterWaitRequest = w_req;
        if (w_granted) begin
            masterWaitRequest         = 2'b11;
            masterWaitRequest[w_sel]  = w_stall;
        end
    end

    always_comb begin
        masterReadValid = 2'b00;
        if (w_pop) begin
            masterReadValid = r_fifo[r_head] ? 2'b10 : 2'b01;
        end
    end

    assign masterReadData = slaveReadData;
    assign protocolError  = r_err;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_req == 2'b11) begin
                    w_state_nxt = r_last ? S_OWN0 : S_OWN1;
                end else if (w_req[0]) begin
                    w_state_nxt = S_OWN0;
                end else if (w_req[1]) begin
                    w_state_nxt = S_OWN1;
                end
            end
            S_OWN0, S_OWN1: begin
                if (w_accept) begin
                    if (w_req[~w_sel]) begin
                        w_state_nxt = w_sel ? S_OWN0 : S_OWN1;
                    end else if (!w_req[w_sel]) begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_req == 2'b00) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_last <= w_sel;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < MAX_PENDING; i++) begin
                r_fifo[i] <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_fifo[r_tail] <= w_sel;
                r_tail         <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master memory bus arbiter for cpu32e2. It shares the single Avalon-style system bus slave port between master 0 (CPU load/store/fetch path) and master 1 (DMA/debug). It grants the bus round-robin and holds the grant across wait-stated transfers. It routes pipelined read returns back to the issuing master through an in-order ID FIFO, and sits between the CPU bus interface and the system interconnect.

## Interface
- ADDR_WIDTH, 32, address width per master and slave
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8
- MAX_PENDING, 4, maximum outstanding reads (ID FIFO depth, power of 2, ≥2)

Packed per-master vectors: master i occupies slice [i*W +: W].

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (low = reset asserted)
- masterRead  in  2  read request per master
- masterWrite  in  2  write request per master
- masterAddress  in  2*ADDR_WIDTH  address per master
- masterWriteData  in  2*DATA_WIDTH  write data per master
- masterByteEnable  in  2*DATA_WIDTH/8  byte enables per master
- masterWaitRequest  out  2  stall to master i; request not accepted this cycle
- masterReadValid  out  2  read data valid for master i
- masterReadData  out  DATA_WIDTH  shared read data (qualify with masterReadValid)
- slaveRead, slaveWrite  out  1 each  request to bus
- slaveAddress  out  ADDR_WIDTH
- slaveWriteData  out  DATA_WIDTH
- slaveByteEnable  out  DATA_WIDTH/8
- slaveWaitRequest  in  1  bus stall
- slaveReadValid  in  1  read return strobe, returns in issue order
- slaveReadData  in  DATA_WIDTH
- protocolError  out  1  sticky error flag, cleared only by reset

## Operation
- State register values:
  - IDLE: no grant.
  - OWN0: master 0 granted.
  - OWN1: master 1 granted.
  - The block also keeps a lastGrant bit.
- request[i] = masterRead[i] | masterWrite[i].
- IDLE transitions:
  - One master requesting → OWNi at the next edge.
  - Both requesting → the master ≠ lastGrant is granted.
- Slave outputs are combinationally muxed from the granted master. In IDLE, slaveRead and slaveWrite are 0; address, data and byte enables are don't-care and driven from master 0.
- accept = granted master's slaveRead|slaveWrite & !slaveWaitRequest. On accept:
  - lastGrant ← granted master.
  - Next state: other master requesting → OWN(other); else same master requesting → stay; else IDLE.
- With no accept, the grant holds, even if the granted master drops its request; it returns to IDLE next edge only if no request is present.
- masterWaitRequest[i]:
  - Granted master: slaveWaitRequest | readBlock.
  - Any other master: 1.
- Read and write asserted together by the granted master: the write is issued, the read is suppressed, and protocolError is set.
- Read ID FIFO:
  - Push the granted master's index on an accepted read.
  - Pop on slaveReadValid.
  - masterReadValid[head] = slaveReadValid; masterReadData = slaveReadData.
- Full FIFO (count = MAX_PENDING):
  - readBlock = 1.
  - slaveRead is forced to 0 and the granted reader sees waitRequest = 1.
  - Writes still proceed.
- Simultaneous push and pop: count unchanged, head and tail both advance, and the push is allowed even when full.
- slaveReadValid with an empty FIFO: the data is dropped, both masterReadValid bits stay 0, and protocolError is set.
- Count width is log2(MAX_PENDING)+1. Pointers wrap modulo MAX_PENDING.

## Timing
- Reset (asynchronous) values:
  - state IDLE, lastGrant 1 (master 0 wins the first tie).
  - FIFO count 0, pointers 0, protocolError 0.
- Resulting outputs during reset: slaveRead and slaveWrite 0; masterReadValid 00; masterWaitRequest = request.
- Reset mid-transfer: in-flight reads are forgotten. Their later slaveReadValid pulses set protocolError and are not forwarded.
- Arbitration latency: a request arriving in IDLE is first presented to the slave in the next cycle, so the minimum latency is 2 cycles to accept.
- Once owned, back-to-back accepts from the same master, or a switch to the waiting master, have zero bubble cycles.
- Read return path is combinational, with zero added latency.
- Fairness: with both masters requesting continuously, grants strictly alternate, one accepted transfer each.

## Test plan
- Reset, then master 0 reads 0x100 with slaveWaitRequest low → slaveRead high in cycle 2. A readValid of 0xDEADBEEF two cycles later → masterReadValid = 01, masterReadData = 0xDEADBEEF.
- Both masters write continuously for 6 transfers → accepted order 0,1,0,1,0,1. The non-granted master sees waitRequest = 1 every cycle.
- Granted master 1 read with slaveWaitRequest high for 3 cycles while master 0 requests → grant stays OWN1 until accept, then switches to OWN0 with no idle cycle.
- Master 0 issues 4 reads with no returns, then a 5th read → the 5th is stalled with slaveRead = 0. A write in the same window is accepted. One readValid releases the 5th read, whose push and pop occur in the same cycle.
- Interleaved reads 0,1,0 with returns delayed → readValid routed to 0,1,0 in order. A stray readValid with an empty FIFO sets protocolError and forwards nothing.
- Assert reset with 2 reads outstanding, release it, then pulse slaveReadValid twice → masterReadValid stays 00 and protocolError = 1.
